scan_line_buffer: RTL and testbench

SCAN_LINE_BUFFER -- requirements
Module: scan_line_buffer

---
 rtl/scan_line_buffer_if.sv | 38 +++
 rtl/scan_line_buffer.sv | 123 ++++++++++++
 tb/tb_scan_line_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_line_buffer_if.sv
// Scan line buffer bus: input-side pixel writes, output-side pixel reads,
// queue control (flush, clear_flags) and status.
//   master : pixel source / display timing side (drives writes, reads, control)
//   slave  : the line buffer (returns read data and status)
interface scan_line_buffer_if #(
   parameter int unsigned PIX_W  = 9,
   parameter int unsigned X_W    = 10,
   parameter int unsigned NLINES = 4
) ();
   localparam int unsigned LR_W = $clog2(NLINES) + 1;

   logic             flush;
   logic             clear_flags;
   logic             in_valid;
   logic [X_W-1:0]   in_x;
   logic [PIX_W-1:0] in_pix;
   logic             in_eol;
   logic [X_W-1:0]   out_x;
   logic             out_active;
   logic             out_eol;
   logic [PIX_W-1:0] out_pix;
   logic             out_valid;
   logic [LR_W-1:0]  lines_ready;
   logic             overrun;
   logic             underrun;

   modport master (
      output flush, clear_flags, in_valid, in_x, in_pix, in_eol,
      output out_x, out_active, out_eol,
      input  out_pix, out_valid, lines_ready, overrun, underrun
   );

   modport slave (
      input  flush, clear_flags, in_valid, in_x, in_pix, in_eol,
      input  out_x, out_active, out_eol,
      output out_pix, out_valid, lines_ready, overrun, underrun
   );
endinterface

// File: rtl/scan_line_buffer.sv
// Multi-bank scan line buffer. The input side writes pixels into the current
// write bank and commits it on in_eol; the output side reads the oldest
// committed bank, re-displays it VREP times, then retires it.
//   pixclk, reset      : clock, synchronous active-high reset
//   bus.flush          : clear queue state (memory retained)
//   bus.clear_flags    : clear sticky overrun/underrun
//   bus.in_*           : pixel write strobe, index, data, end-of-line
//   bus.out_x/active/eol : display read index, visible region, end-of-line
//   bus.out_pix/valid  : registered read data (1-cycle latency)
//   bus.lines_ready    : committed lines not yet retired
//   bus.overrun/underrun : sticky error flags
module scan_line_buffer #(
   parameter int unsigned PIX_W  = 9,
   parameter int unsigned X_W    = 10,
   parameter int unsigned NLINES = 4,
   parameter int unsigned VREP   = 2,
   parameter int unsigned HSHIFT = 0
) (
   input  logic pixclk,
   input  logic reset,
   scan_line_buffer_if.slave bus
);
   localparam int unsigned BANK_W = $clog2(NLINES);
   localparam int unsigned LR_W   = BANK_W + 1;
   localparam int unsigned REP_W  = (VREP > 1) ? $clog2(VREP) : 1;
   localparam int unsigned DEPTH  = NLINES << X_W;

   logic [PIX_W-1:0]  mem [DEPTH];
   logic [BANK_W-1:0] wr_bank;
   logic [BANK_W-1:0] rd_bank;
   logic [REP_W-1:0]  rep_cnt;
   logic [LR_W-1:0]   lines_ready;

   logic [X_W-1:0] rd_x_c;
   logic           have_line_c;
   logic           last_rep_c;
   logic           retire_c;
   logic           commit_c;
   logic           drop_c;
   logic           starve_c;

   // Queue events; a retire in the same cycle frees room for a commit.
   always_comb begin
      rd_x_c      = X_W'(bus.out_x >> HSHIFT);
      have_line_c = (lines_ready != '0);
      last_rep_c  = (rep_cnt == REP_W'(VREP - 1));
      retire_c    = bus.out_eol & have_line_c & last_rep_c;
      commit_c    = bus.in_eol & ((lines_ready < LR_W'(NLINES - 1)) | retire_c);
      drop_c      = bus.in_eol & ~commit_c;
      starve_c    = bus.out_eol & ~have_line_c;
   end

   // Pixel storage; not cleared by reset or flush.
   always_ff @(posedge pixclk) begin
      if (!reset && bus.in_valid) begin
         mem[{wr_bank, bus.in_x}] <= bus.in_pix;
      end
   end

   // Read port, 1-cycle latency; returns pre-write data on an address collision.
   always_ff @(posedge pixclk) begin
      if (reset || bus.flush) begin
         bus.out_pix   <= '0;
         bus.out_valid <= 1'b0;
      end else if (bus.out_active && have_line_c) begin
         bus.out_pix   <= mem[{rd_bank, rd_x_c}];
         bus.out_valid <= 1'b1;
      end else begin
         bus.out_pix   <= '0;
         bus.out_valid <= 1'b0;
      end
   end

   // Bank pointers, repeat counter and occupancy.
   always_ff @(posedge pixclk) begin
      if (reset || bus.flush) begin
         wr_bank     <= '0;
         rd_bank     <= '0;
         rep_cnt     <= '0;
         lines_ready <= '0;
      end else begin
         if (commit_c) begin
            wr_bank <= wr_bank + 1'b1;
         end
         if (bus.out_eol) begin
            if (!have_line_c || last_rep_c) begin
               rep_cnt <= '0;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
            if (retire_c) begin
               rd_bank <= rd_bank + 1'b1;
            end
         end
         case ({commit_c, retire_c})
            2'b10:   lines_ready <= lines_ready + 1'b1;
            2'b01:   lines_ready <= lines_ready - 1'b1;
            default: lines_ready <= lines_ready;
         endcase
      end
   end

   // Sticky flags; a set event beats clear_flags, flush suppresses events.
   always_ff @(posedge pixclk) begin
      if (reset) begin
         bus.overrun  <= 1'b0;
         bus.underrun <= 1'b0;
      end else begin
         if (bus.clear_flags) begin
            bus.overrun  <= 1'b0;
            bus.underrun <= 1'b0;
         end
         if (!bus.flush && drop_c) begin
            bus.overrun <= 1'b1;
         end
         if (!bus.flush && starve_c) begin
            bus.underrun <= 1'b1;
         end
      end
   end

   assign bus.lines_ready = lines_ready;
endmodule

// File: tb/tb_scan_line_buffer.sv
// Self-checking bench for scan_line_buffer: directed scenarios plus a
// randomized run checked against a line-queue reference model.
module tb_scan_line_buffer;
   localparam int unsigned PIX_W  = 9;
   localparam int unsigned X_W    = 10;
   localparam int unsigned NLINES = 4;
   localparam int unsigned VREP   = 2;
   localparam int unsigned LINE   = 1 << X_W;
   localparam int unsigned LR_W   = $clog2(NLINES) + 1;

   logic pixclk = 1'b0;
   logic reset;
   always #5 pixclk = ~pixclk;

   scan_line_buffer_if #(.PIX_W(PIX_W), .X_W(X_W), .NLINES(NLINES)) bus ();
   scan_line_buffer_if #(.PIX_W(PIX_W), .X_W(X_W), .NLINES(NLINES)) bus2 ();

   scan_line_buffer #(.PIX_W(PIX_W), .X_W(X_W), .NLINES(NLINES), .VREP(VREP), .HSHIFT(0))
      dut (.pixclk(pixclk), .reset(reset), .bus(bus));
   scan_line_buffer #(.PIX_W(PIX_W), .X_W(X_W), .NLINES(NLINES), .VREP(VREP), .HSHIFT(1))
      dut_h (.pixclk(pixclk), .reset(reset), .bus(bus2));

   // Reference model: per-bank line images plus queue bookkeeping.
   logic [PIX_W-1:0] mm [NLINES][LINE];
   int               m_wr, m_rd, m_rep, m_lr;
   logic             m_ovr, m_und, m_val;
   logic [PIX_W-1:0] m_pix;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic idle();
      bus.flush = 0; bus.clear_flags = 0; bus.in_valid = 0; bus.in_x = '0;
      bus.in_pix = '0; bus.in_eol = 0; bus.out_x = '0; bus.out_active = 0; bus.out_eol = 0;
      bus2.flush = 0; bus2.clear_flags = 0; bus2.in_valid = 0; bus2.in_x = '0;
      bus2.in_pix = '0; bus2.in_eol = 0; bus2.out_x = '0; bus2.out_active = 0; bus2.out_eol = 0;
   endtask

   // Advance one clock and apply the same edge to the model.
   task automatic tick();
      bit retire;
      @(posedge pixclk);
      if (reset) begin
         m_wr = 0; m_rd = 0; m_rep = 0; m_lr = 0;
         m_ovr = 0; m_und = 0; m_val = 0; m_pix = '0;
      end else begin
         if (!bus.flush && bus.out_active && m_lr > 0) begin
            m_val = 1; m_pix = mm[m_rd][bus.out_x];
         end else begin
            m_val = 0; m_pix = '0;
         end
         if (bus.in_valid) mm[m_wr][bus.in_x] = bus.in_pix;
         if (bus.clear_flags) begin m_ovr = 0; m_und = 0; end
         if (bus.flush) begin
            m_wr = 0; m_rd = 0; m_rep = 0; m_lr = 0;
         end else begin
            retire = bus.out_eol && m_lr > 0 && m_rep == VREP - 1;
            if (bus.out_eol) begin
               if (m_lr == 0) begin m_und = 1; m_rep = 0; end
               else if (m_rep == VREP - 1) begin m_rep = 0; m_rd = (m_rd + 1) % NLINES; end
               else m_rep = m_rep + 1;
            end
            if (bus.in_eol) begin
               if (m_lr < NLINES - 1 || retire) begin
                  m_wr = (m_wr + 1) % NLINES; m_lr = m_lr + 1;
               end else m_ovr = 1;
            end
            if (retire) m_lr = m_lr - 1;
         end
      end
      #1;
   endtask

   task automatic put(input int x, input logic [PIX_W-1:0] p, input logic eol);
      bus.in_valid = 1; bus.in_x = X_W'(x); bus.in_pix = p; bus.in_eol = eol;
      tick(); idle();
   endtask

   task automatic ev(input logic ie, input logic oe);
      bus.in_eol = ie; bus.out_eol = oe;
      tick(); idle();
   endtask

   task automatic rd(input int x);
      bus.out_active = 1; bus.out_x = X_W'(x);
      tick(); idle();
   endtask

   task automatic flush_clear();
      bus.flush = 1; bus.clear_flags = 1;
      tick(); idle();
   endtask

   task automatic test_reset();
      reset = 1; tick(); tick();
      n_cmp += 5;
      if (bus.out_pix !== '0) begin $display("FAIL rst_pix got %h want 0", bus.out_pix); n_bad++; end
      if (bus.out_valid !== 1'b0) begin $display("FAIL rst_valid got %b want 0", bus.out_valid); n_bad++; end
      if (bus.lines_ready !== '0) begin $display("FAIL rst_lr got %0d want 0", bus.lines_ready); n_bad++; end
      if (bus.overrun !== 1'b0) begin $display("FAIL rst_ovr got %b want 0", bus.overrun); n_bad++; end
      if (bus.underrun !== 1'b0) begin $display("FAIL rst_und got %b want 0", bus.underrun); n_bad++; end
      reset = 0;
   endtask

   // Fill every bank with random data; the fourth line overruns into bank 3.
   task automatic test_fill();
      for (int b = 0; b < int'(NLINES); b++) begin
         for (int x = 0; x < int'(LINE); x++) begin
            put(x, PIX_W'($urandom), x == int'(LINE) - 1);
         end
      end
      n_cmp += 2;
      if (bus.lines_ready !== LR_W'(3)) begin $display("FAIL fill_lr got %0d want 3", bus.lines_ready); n_bad++; end
      if (bus.overrun !== 1'b1) begin $display("FAIL fill_ovr got %b want 1", bus.overrun); n_bad++; end
      flush_clear();
      n_cmp += 2;
      if (bus.lines_ready !== '0) begin $display("FAIL flush_lr got %0d want 0", bus.lines_ready); n_bad++; end
      if (bus.overrun !== 1'b0) begin $display("FAIL clear_ovr got %b want 0", bus.overrun); n_bad++; end
   endtask

   task automatic test_basic();
      for (int x = 0; x < int'(LINE); x++) put(x, PIX_W'(x), x == int'(LINE) - 1);
      rd(5);
      n_cmp += 3;
      if (bus.out_pix !== PIX_W'(5)) begin $display("FAIL basic_pix got %h want 005", bus.out_pix); n_bad++; end
      if (bus.out_valid !== 1'b1) begin $display("FAIL basic_valid got %b want 1", bus.out_valid); n_bad++; end
      if (bus.lines_ready !== LR_W'(1)) begin $display("FAIL basic_lr got %0d want 1", bus.lines_ready); n_bad++; end
      rd(1023);
      n_cmp++;
      if (bus.out_pix !== 9'h1FF) begin $display("FAIL basic_last got %h want 1ff", bus.out_pix); n_bad++; end
   endtask

   task automatic test_repeat();
      ev(0, 1); rd(5);
      n_cmp += 2;
      if (bus.lines_ready !== LR_W'(1)) begin $display("FAIL rep1_lr got %0d want 1", bus.lines_ready); n_bad++; end
      if (bus.out_pix !== PIX_W'(5)) begin $display("FAIL rep1_pix got %h want 005", bus.out_pix); n_bad++; end
      ev(0, 1); rd(5);
      n_cmp += 3;
      if (bus.lines_ready !== '0) begin $display("FAIL rep2_lr got %0d want 0", bus.lines_ready); n_bad++; end
      if (bus.out_valid !== 1'b0) begin $display("FAIL rep2_valid got %b want 0", bus.out_valid); n_bad++; end
      if (bus.out_pix !== '0) begin $display("FAIL rep2_pix got %h want 0", bus.out_pix); n_bad++; end
      put(5, 9'h0AA, 1); rd(5);
      n_cmp++;
      if (bus.out_pix !== 9'h0AA) begin $display("FAIL rep_bank1 got %h want 0aa", bus.out_pix); n_bad++; end
   endtask

   task automatic test_overrun();
      flush_clear();
      for (int k = 0; k < 4; k++) begin
         put(9, PIX_W'(9'h100 + k), 1);
         if (k >= 2) begin
            n_cmp += 2;
            if (bus.lines_ready !== LR_W'(3)) begin $display("FAIL ovr_lr%0d got %0d want 3", k, bus.lines_ready); n_bad++; end
            if (bus.overrun !== (k == 3)) begin $display("FAIL ovr_flag%0d got %b want %b", k, bus.overrun, k == 3); n_bad++; end
         end
      end
      rd(9);
      n_cmp++;
      if (bus.out_pix !== 9'h100) begin $display("FAIL ovr_head got %h want 100", bus.out_pix); n_bad++; end
      ev(0, 1); ev(0, 1);
      put(9, 9'h1EE, 1);
      for (int k = 0; k < 4; k++) ev(0, 1);
      rd(9);
      n_cmp += 2;
      if (bus.lines_ready !== LR_W'(1)) begin $display("FAIL ovr_tail_lr got %0d want 1", bus.lines_ready); n_bad++; end
      if (bus.out_pix !== 9'h1EE) begin $display("FAIL ovr_rewrite got %h want 1ee", bus.out_pix); n_bad++; end
   endtask

   task automatic test_underrun();
      flush_clear();
      ev(0, 1); rd(3);
      n_cmp += 2;
      if (bus.underrun !== 1'b1) begin $display("FAIL und_set got %b want 1", bus.underrun); n_bad++; end
      if (bus.out_valid !== 1'b0) begin $display("FAIL und_valid got %b want 0", bus.out_valid); n_bad++; end
      bus.clear_flags = 1; bus.out_eol = 1; tick(); idle();
      n_cmp++;
      if (bus.underrun !== 1'b1) begin $display("FAIL und_setwins got %b want 1", bus.underrun); n_bad++; end
      bus.clear_flags = 1; tick(); idle();
      n_cmp++;
      if (bus.underrun !== 1'b0) begin $display("FAIL und_clear got %b want 0", bus.underrun); n_bad++; end
   endtask

   task automatic test_back_to_back();
      flush_clear();
      put(2, 9'h011, 1); put(2, 9'h022, 1); put(2, 9'h033, 1);
      ev(0, 1); ev(1, 1);
      n_cmp += 2;
      if (bus.lines_ready !== LR_W'(3)) begin $display("FAIL b2b_lr got %0d want 3", bus.lines_ready); n_bad++; end
      if (bus.overrun !== 1'b0) begin $display("FAIL b2b_ovr got %b want 0", bus.overrun); n_bad++; end
      rd(2);
      n_cmp++;
      if (bus.out_pix !== 9'h022) begin $display("FAIL b2b_rd got %h want 022", bus.out_pix); n_bad++; end
      bus.flush = 1; bus.in_eol = 1; bus.out_eol = 1; tick(); idle();
      n_cmp += 2;
      if (bus.lines_ready !== '0) begin $display("FAIL b2b_flush_lr got %0d want 0", bus.lines_ready); n_bad++; end
      if (bus.underrun !== 1'b0) begin $display("FAIL b2b_flush_und got %b want 0", bus.underrun); n_bad++; end
      put(2, 9'h055, 1); rd(2);
      n_cmp++;
      if (bus.out_pix !== 9'h055) begin $display("FAIL b2b_bank0 got %h want 055", bus.out_pix); n_bad++; end
   endtask

   task automatic test_hshift();
      bus2.in_valid = 1; bus2.in_x = X_W'(3); bus2.in_pix = 9'h1A3; bus2.in_eol = 1;
      tick(); idle();
      for (int x = 6; x <= 7; x++) begin
         bus2.out_active = 1; bus2.out_x = X_W'(x);
         tick(); idle();
         n_cmp += 2;
         if (bus2.out_pix !== 9'h1A3) begin $display("FAIL hshift_x%0d got %h want 1a3", x, bus2.out_pix); n_bad++; end
         if (bus2.out_valid !== 1'b1) begin $display("FAIL hshift_v%0d got %b want 1", x, bus2.out_valid); n_bad++; end
      end
   endtask

   task automatic test_reset_midline();
      flush_clear();
      put(7, 9'h0F0, 0); put(8, 9'h0F1, 0);
      reset = 1; bus.in_eol = 1; tick(); idle(); reset = 0;
      n_cmp += 2;
      if (bus.lines_ready !== '0) begin $display("FAIL midrst_lr got %0d want 0", bus.lines_ready); n_bad++; end
      if (bus.overrun !== 1'b0) begin $display("FAIL midrst_ovr got %b want 0", bus.overrun); n_bad++; end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 599) == 0);
         bus.flush       = ($urandom_range(0, 199) == 0);
         bus.clear_flags = ($urandom_range(0, 49) == 0);
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.in_x        = X_W'($urandom);
         bus.in_pix      = PIX_W'($urandom);
         bus.in_eol      = ($urandom_range(0, 11) == 0);
         bus.out_x       = X_W'($urandom);
         bus.out_active  = ($urandom_range(0, 3) != 0);
         bus.out_eol     = ($urandom_range(0, 9) == 0);
         tick();
         n_cmp += 5;
         if (!$isunknown(m_pix) && bus.out_pix !== m_pix) begin
            $display("FAIL rnd_pix@%0d got %h want %h", i, bus.out_pix, m_pix); n_bad++;
         end
         if (bus.out_valid !== m_val) begin $display("FAIL rnd_valid@%0d got %b want %b", i, bus.out_valid, m_val); n_bad++; end
         if (bus.lines_ready !== LR_W'(m_lr)) begin $display("FAIL rnd_lr@%0d got %0d want %0d", i, bus.lines_ready, m_lr); n_bad++; end
         if (bus.overrun !== m_ovr) begin $display("FAIL rnd_ovr@%0d got %b want %b", i, bus.overrun, m_ovr); n_bad++; end
         if (bus.underrun !== m_und) begin $display("FAIL rnd_und@%0d got %b want %b", i, bus.underrun, m_und); n_bad++; end
      end
      reset = 0; idle();
   endtask

   initial begin
      for (int b = 0; b < int'(NLINES); b++)
         for (int x = 0; x < int'(LINE); x++) mm[b][x] = 'x;
      m_wr = 0; m_rd = 0; m_rep = 0; m_lr = 0;
      m_ovr = 0; m_und = 0; m_val = 0; m_pix = '0;
      idle();
      test_reset();
      test_fill();
      test_basic();
      test_repeat();
      test_overrun();
      test_underrun();
      test_back_to_back();
      test_hshift();
      test_reset_midline();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
